psx_pad_emulator: RTL

- Next-generation PlayStation controller emulator, synchronous to the system clock.
- Oversamples the console-side psx_clk, psx_cmd and psx_att lines and decodes the address and poll commands.
- Returns a digital (ID 0x41, 5 bytes) or analog (ID 0x73, 9 bytes) response from live button and stick inputs.
- Generates ack pulses with programmable delay and width in clk cycles. This replaces the RC-timed ack scheme; it sits between the board-level PSX port pins and the input-capture logic.

---
 rtl/psx_pad_emulator_if.sv | 26 ++
 rtl/psx_pad_emulator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psx_pad_emulator_if.sv
// PSX controller port bundle: console-driven shift lines plus pad-driven data/ack.
// Handshake: the console shifts a byte while psx_att is low; the pad answers each accepted
// byte except the last with one low pulse on ack, and the console waits for it before the next byte.
interface psx_pad_emulator_if;
   logic psx_clk;
   logic psx_cmd;
   logic psx_att;
   logic data;
   logic ack;

   modport master (
      output psx_clk,
      output psx_cmd,
      output psx_att,
      input  data,
      input  ack
   );

   modport slave (
      input  psx_clk,
      input  psx_cmd,
      input  psx_att,
      output data,
      output ack
   );
endinterface

// File: rtl/psx_pad_emulator.sv
// PlayStation pad emulator: oversamples the console lines, decodes address/poll and
// returns a digital (0x41) or analog (0x73) response with clk-timed ack pulses.
module psx_pad_emulator #(
   parameter int          SYNC_STAGES = 2,
   parameter int          ACK_DELAY   = 4,
   parameter int          ACK_WIDTH   = 3,
   parameter logic [7:0]  PAD_ADDR    = 8'h01,
   parameter logic [7:0]  POLL_CMD    = 8'h42
) (
   input  logic                clk,
   input  logic                rst,
   psx_pad_emulator_if.slave   pad,
   input  logic [15:0]         buttons,
   input  logic [7:0]          stick_rx,
   input  logic [7:0]          stick_ry,
   input  logic [7:0]          stick_lx,
   input  logic [7:0]          stick_ly,
   input  logic                analog_mode,
   output logic                busy,
   output logic                poll_done,
   output logic [2:0]          dbg_state
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SHIFT     = 3'd1,
      ACK_WAIT  = 3'd2,
      ACK_PULSE = 3'd3,
      DONE      = 3'd4
   } state_e;

   localparam logic [7:0] DELAY_M1 = 8'(ACK_DELAY - 1);
   localparam logic [7:0] WIDTH_M1 = 8'(ACK_WIDTH - 1);

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] cmd_sync_q, cmd_sync_d;
   logic [SYNC_STAGES-1:0] att_sync_q, att_sync_d;
   logic                   clk_prev_q, clk_prev_d;
   logic                   att_prev_q, att_prev_d;
   logic [2:0]             bit_idx_q, bit_idx_d;
   logic [3:0]             byte_idx_q, byte_idx_d;
   logic [3:0]             resp_len_q, resp_len_d;
   logic [7:0]             tx_q, tx_d;
   logic [7:0]             rx_q, rx_d;
   logic [7:0]             cnt_q, cnt_d;
   logic                   fall_pend_q, fall_pend_d;
   logic                   data_q, data_d;
   logic                   ack_q, ack_d;
   logic                   poll_done_q, poll_done_d;
   logic [15:0]            btn_q, btn_d;
   logic [7:0]             rx_axis_q, rx_axis_d;
   logic [7:0]             ry_axis_q, ry_axis_d;
   logic [7:0]             lx_axis_q, lx_axis_d;
   logic [7:0]             ly_axis_q, ly_axis_d;
   logic                   analog_q, analog_d;

   logic       clk_s, cmd_s, att_s;
   logic       fall, rise, start;
   logic [7:0] rx_byte;
   logic [7:0] next_tx;

   assign clk_s = clk_sync_q[SYNC_STAGES-1];
   assign cmd_s = cmd_sync_q[SYNC_STAGES-1];
   assign att_s = att_sync_q[SYNC_STAGES-1];
   assign fall  = clk_prev_q & ~clk_s;
   assign rise  = ~clk_prev_q & clk_s;
   assign start = att_prev_q & ~att_s;

   assign pad.data  = data_q;
   assign pad.ack   = ack_q;
   assign busy      = (state_q != IDLE);
   assign poll_done = poll_done_q;
   assign dbg_state = state_q;

   function automatic logic [7:0] resp_byte(input logic [3:0] idx);
      case (idx)
         4'd0:    resp_byte = 8'hFF;
         4'd1:    resp_byte = analog_q ? 8'h73 : 8'h41;
         4'd2:    resp_byte = 8'h5A;
         4'd3:    resp_byte = btn_q[7:0];
         4'd4:    resp_byte = btn_q[15:8];
         4'd5:    resp_byte = rx_axis_q;
         4'd6:    resp_byte = ry_axis_q;
         4'd7:    resp_byte = lx_axis_q;
         4'd8:    resp_byte = ly_axis_q;
         default: resp_byte = 8'hFF;
      endcase
   endfunction

   always_comb begin
      clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], pad.psx_clk};
      cmd_sync_d  = {cmd_sync_q[SYNC_STAGES-2:0], pad.psx_cmd};
      att_sync_d  = {att_sync_q[SYNC_STAGES-2:0], pad.psx_att};
      clk_prev_d  = clk_s;
      att_prev_d  = att_s;
      state_d     = state_q;
      bit_idx_d   = bit_idx_q;
      byte_idx_d  = byte_idx_q;
      resp_len_d  = resp_len_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      cnt_d       = cnt_q;
      fall_pend_d = fall_pend_q;
      data_d      = data_q;
      ack_d       = ack_q;
      poll_done_d = 1'b0;
      btn_d       = btn_q;
      rx_axis_d   = rx_axis_q;
      ry_axis_d   = ry_axis_q;
      lx_axis_d   = lx_axis_q;
      ly_axis_d   = ly_axis_q;
      analog_d    = analog_q;
      rx_byte     = rx_q;
      rx_byte[bit_idx_q] = cmd_s;
      next_tx     = resp_byte(byte_idx_q + 4'd1);

      case (state_q)
         IDLE: begin
            data_d = 1'b1;
            ack_d  = 1'b1;
            if (start) begin
               btn_d       = buttons;
               rx_axis_d   = stick_rx;
               ry_axis_d   = stick_ry;
               lx_axis_d   = stick_lx;
               ly_axis_d   = stick_ly;
               analog_d    = analog_mode;
               resp_len_d  = analog_mode ? 4'd9 : 4'd5;
               tx_d        = 8'hFF;
               byte_idx_d  = 4'd0;
               bit_idx_d   = 3'd0;
               fall_pend_d = 1'b0;
               state_d     = SHIFT;
            end
         end
         SHIFT: begin
            if (fall) begin
               data_d = tx_q[bit_idx_q];
            end else if (rise) begin
               rx_d      = rx_byte;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  if ((byte_idx_q == 4'd0 && rx_byte != PAD_ADDR) ||
                      (byte_idx_q == 4'd1 && rx_byte != POLL_CMD)) begin
                     data_d  = 1'b1;
                     state_d = DONE;
                  end else if (byte_idx_q == resp_len_q - 4'd1) begin
                     data_d      = 1'b1;
                     poll_done_d = 1'b1;
                     state_d     = DONE;
                  end else begin
                     cnt_d       = 8'd0;
                     fall_pend_d = 1'b0;
                     state_d     = ACK_WAIT;
                  end
               end
            end
         end
         ACK_WAIT: begin
            if (fall) fall_pend_d = 1'b1;
            if (cnt_q == DELAY_M1) begin
               ack_d   = 1'b0;
               cnt_d   = 8'd0;
               state_d = ACK_PULSE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ACK_PULSE: begin
            if (fall) fall_pend_d = 1'b1;
            if (cnt_q == WIDTH_M1) begin
               ack_d       = 1'b1;
               byte_idx_d  = byte_idx_q + 4'd1;
               tx_d        = next_tx;
               bit_idx_d   = 3'd0;
               fall_pend_d = 1'b0;
               state_d     = SHIFT;
               // A console that clocked early already expects bit 0 of the new byte.
               if (fall_pend_q || fall) data_d = next_tx[0];
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            data_d = 1'b1;
            ack_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE && att_s) begin
         state_d     = IDLE;
         data_d      = 1'b1;
         ack_d       = 1'b1;
         poll_done_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync_q  <= '1;
         cmd_sync_q  <= '1;
         // Held low so a console still holding attention low cannot look like a new start.
         att_sync_q  <= '0;
         clk_prev_q  <= 1'b1;
         att_prev_q  <= 1'b0;
         state_q     <= IDLE;
         bit_idx_q   <= 3'd0;
         byte_idx_q  <= 4'd0;
         resp_len_q  <= 4'd5;
         tx_q        <= 8'hFF;
         rx_q        <= 8'h00;
         cnt_q       <= 8'd0;
         fall_pend_q <= 1'b0;
         data_q      <= 1'b1;
         ack_q       <= 1'b1;
         poll_done_q <= 1'b0;
         btn_q       <= 16'hFFFF;
         rx_axis_q   <= 8'h80;
         ry_axis_q   <= 8'h80;
         lx_axis_q   <= 8'h80;
         ly_axis_q   <= 8'h80;
         analog_q    <= 1'b0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         cmd_sync_q  <= cmd_sync_d;
         att_sync_q  <= att_sync_d;
         clk_prev_q  <= clk_prev_d;
         att_prev_q  <= att_prev_d;
         state_q     <= state_d;
         bit_idx_q   <= bit_idx_d;
         byte_idx_q  <= byte_idx_d;
         resp_len_q  <= resp_len_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         cnt_q       <= cnt_d;
         fall_pend_q <= fall_pend_d;
         data_q      <= data_d;
         ack_q       <= ack_d;
         poll_done_q <= poll_done_d;
         btn_q       <= btn_d;
         rx_axis_q   <= rx_axis_d;
         ry_axis_q   <= ry_axis_d;
         lx_axis_q   <= lx_axis_d;
         ly_axis_q   <= ly_axis_d;
         analog_q    <= analog_d;
      end
   end

endmodule
